// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: result word width, packed field layout and the
// default depth of the result buffer.
package cordic_pkg;

  localparam int RESULT_WIDTH = 32;

  // Packed result word layout: x/degree low, y (or zero) high.
  localparam int RES_LO_MSB = 15;
  localparam int RES_LO_LSB = 0;
  localparam int RES_HI_MSB = 31;
  localparam int RES_HI_LSB = 16;

  localparam int FIFO_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/cordic_result_fifo_mem.sv
// Simple dual-port storage for the result FIFO: synchronous write,
// asynchronous read. Contents are intentionally not reset.
module cordic_result_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: one word per cycle at waddr.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cordic_result_fifo.sv
// Result buffer behind the non-stallable CORDIC output stage. Captures every
// valid result word, hands it to the host over valid/ready, and drops (and
// flags) words that arrive while full and not draining.
// Optional feature macro: CORDIC_RESULT_DROP_CNT_EN adds a saturating
// drop_count output alongside the sticky overflow bit.
module cordic_result_fifo
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH     = RESULT_WIDTH,
  parameter int DEPTH          = FIFO_DEPTH_DEFAULT,
  parameter int ADDR_WIDTH     = 3
`ifdef CORDIC_RESULT_DROP_CNT_EN
  ,
  parameter int DROP_CNT_WIDTH = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH:0]       level,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  input  logic                      clear_status
`ifdef CORDIC_RESULT_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
`endif
);

  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  push, pop, drop;
  logic [DATA_WIDTH-1:0] rd_data;

  // Handshake decode, pointer/level next-state and sticky drop flag.
  always_comb begin
    pop  = !empty_q & out_ready;
    // A full queue still accepts a word when the head leaves this cycle.
    push = in_valid & (!full_q | pop);
    drop = in_valid & full_q & !pop;

    wr_ptr_d = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LEVEL_FULL);
    empty_d = (level_d == '0);

    // A drop in the same cycle as a clear must stay visible.
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (clear_status) overflow_d = 1'b0;
  end

  // Queue state registers; reset discards all queued words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  cordic_result_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push & !rst),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

`ifdef CORDIC_RESULT_DROP_CNT_EN
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = '1;

  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a drop coinciding with a clear restarts at one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      if (clear_status)             drop_cnt_d = DROP_CNT_WIDTH'(1);
      else if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end else if (clear_status) begin
      drop_cnt_d = '0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  // Head word is masked to zero whenever the queue is empty.
  assign out_data  = empty_q ? '0 : rd_data;
  assign out_valid = !empty_q;
  assign level     = level_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Self-checking bench for cordic_result_fifo: directed scenarios plus a
// randomized phase, all checked against a queue-based reference model.
module tb_cordic_result_fifo;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, clear_status;
  logic [31:0] in_data, out_data;
  logic        out_valid, full, empty, overflow;
  logic [3:0]  level;
`ifdef CORDIC_RESULT_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  cordic_result_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clear_status (clear_status)
`ifdef CORDIC_RESULT_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mq[$];
  bit          m_ov;
  int          m_dc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_outs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_data",  out_data, (mq.size() != 0) ? mq[0] : 32'h0);
    chk("level",     32'(level), 32'(mq.size()));
    chk("full",      32'(full),  32'(mq.size() == 8));
    chk("empty",     32'(empty), 32'(mq.size() == 0));
    chk("overflow",  32'(overflow), 32'(m_ov));
`ifdef CORDIC_RESULT_DROP_CNT_EN
    chk("drop_count", 32'(drop_count), 32'(m_dc));
`endif
  endtask

  // One clock: apply inputs, advance the model, check after the edge.
  task automatic cyc(input bit r, input bit v, input logic [31:0] d, input bit rdy, input bit clr);
    bit full_m, pop_m, drop_m;
    rst = r; in_valid = v; in_data = d; out_ready = rdy; clear_status = clr;
    full_m = (mq.size() == 8);
    pop_m  = (mq.size() != 0) && rdy;
    drop_m = v && full_m && !pop_m;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete(); m_ov = 0; m_dc = 0;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (v && (!full_m || pop_m)) mq.push_back(d);
      if (drop_m) begin
        m_ov = 1;
        m_dc = clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
      end else if (clr) begin
        m_ov = 0; m_dc = 0;
      end
    end
    check_outs();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0; clear_status = 0;
    m_ov = 0; m_dc = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_data",  out_data, 32'h0);

    // Single word, no fall-through, then pop.
    cyc(0, 1, 32'h0012_0034, 0, 0);
    chk("one_data",  out_data, 32'h0012_0034);
    chk("one_level", 32'(level), 32'd1);
    cyc(0, 0, 0, 1, 0);
    chk("one_empty", 32'(empty), 32'd1);
    chk("one_zero",  out_data, 32'h0);

    // Fill, drop the ninth, drain in order.
    for (int i = 1; i <= 8; i++) cyc(0, 1, 32'(i), 0, 0);
    chk("fill_full",  32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd8);
    cyc(0, 1, 32'h9, 0, 0);
    chk("drop_ov", 32'(overflow), 32'd1);
`ifdef CORDIC_RESULT_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_count), 32'd1);
`endif
    for (int i = 1; i <= 8; i++) begin
      chk("drain_seq", out_data, 32'(i));
      cyc(0, 0, 0, 1, 0);
    end

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 8; i++) cyc(0, 1, 32'(i), 0, 0);
    cyc(0, 1, 32'hA, 1, 0);
    chk("pp_level", 32'(level), 32'd8);
    for (int i = 2; i <= 8; i++) cyc(0, 0, 0, 1, 0);
    chk("pp_last", out_data, 32'hA);
    cyc(0, 0, 0, 1, 0);

    // Backpressure: head must hold.
    for (int i = 0; i < 3; i++) cyc(0, 1, 32'hC0DE_0000 + 32'(i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("hold_data", out_data, 32'hC0DE_0000);
    end

    // Clear alone, then clear coinciding with a drop, then clear alone.
    cyc(0, 0, 0, 0, 1);
    chk("clr_ov", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h100 + 32'(i), 0, 0);
    cyc(0, 1, 32'h55, 0, 1);
    chk("clrdrop_ov", 32'(overflow), 32'd1);
`ifdef CORDIC_RESULT_DROP_CNT_EN
    chk("clrdrop_cnt", 32'(drop_count), 32'd1);
`endif
    cyc(0, 0, 0, 0, 1);
    chk("clr2_ov", 32'(overflow), 32'd0);
`ifdef CORDIC_RESULT_DROP_CNT_EN
    chk("clr2_cnt", 32'(drop_count), 32'd0);
`endif

    // Reset mid-stream at level 5; in_valid ignored during reset.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    chk("pre_rst_level", 32'(level), 32'd5);
    cyc(1, 1, 32'hFF, 0, 0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    cyc(0, 1, 32'h7, 0, 0);
    chk("post_rst_first", out_data, 32'h7);

    // Randomized phases with varying fill/drain bias.
    for (int ph = 0; ph < 8; ph++) begin
      int pv, pr;
      pv = (ph % 2 == 0) ? 85 : 30;
      pr = (ph % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 60; i++) begin
        cyc(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < pv),
            $urandom,
            ($urandom_range(0, 99) < pr),
            ($urandom_range(0, 19) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
